// File: rtl/issue_queue.sv
// Circular dual-issue buffer between decode and the issue/execute register.
// Accepts up to two entries per cycle and presents up to two head entries under the pairing rules.
package issue_queue_pkg;
  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [4:0] rd;
    logic       rd_we;
    logic [4:0] rs;
    logic       rs_re;
    logic [4:0] rt;
    logic       rt_re;
    logic       is_mem;
    logic       is_branch;
  } fu_require_t;
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flash,
  input  fu_require_t [1:0]    id_in,
  input  logic [1:0]           id_valid,
  output logic                 iq_ready,
  output fu_require_t [1:0]    is_out,
  output logic [CNT_W-1:0]     iq_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fu_require_t            mem_q [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]       head1, tail1;
  logic [CNT_W-1:0]       count_q, count_d;
  fu_require_t            h0, h1;
  logic                   raw_hazard, mem_pair;
  logic                   issue0, issue1;
  logic                   enq_en;
  logic [1:0]             enq_cnt, deq_cnt;

  assign head1    = head_q + PTR_W'(1);
  assign tail1    = tail_q + PTR_W'(1);
  assign h0       = mem_q[head_q];
  assign h1       = mem_q[head1];

  // Registered count only: a same-cycle dequeue does not free space for decode.
  assign iq_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign iq_count = count_q;

  always_comb begin
    raw_hazard = h0.rd_we && (h0.rd != 5'd0) &&
                 ((h1.rs_re && (h1.rs == h0.rd)) || (h1.rt_re && (h1.rt == h0.rd)));
    mem_pair   = h0.is_mem && h1.is_mem;
    issue0     = (count_q != '0) && !stall;
    issue1     = issue0 && (count_q >= CNT_W'(2)) && !raw_hazard && !mem_pair && !h1.is_branch;
    is_out[0]  = issue0 ? h0 : '0;
    is_out[1]  = issue1 ? h1 : '0;
  end

  always_comb begin
    enq_en  = iq_ready && !flash && id_valid[0];
    enq_cnt = enq_en ? (id_valid[1] ? 2'd2 : 2'd1) : 2'd0;
    deq_cnt = {1'b0, issue0} + {1'b0, issue1};
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_cnt);
      tail_d  = tail_q + PTR_W'(enq_cnt);
      count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Flash only resets pointers; stale entries are unreachable until rewritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_en) begin
      mem_q[tail_q] <= id_in[0];
      if (id_valid[1]) mem_q[tail1] <= id_in[1];
    end
  end

endmodule
